// File: rtl/axi_ad6676_chan_pack.sv
// Packs pairs of 32-bit ADC beats into 64-bit words and buffers them in a first-word-fall-through FIFO.
// Define AXI_AD6676_CHAN_PACK_OVF_CNT_EN to implement the saturating dropped-word counter on ovf_count.
module axi_ad6676_chan_pack #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        adc_clk,
    input  logic        adc_rst,
    input  logic        adc_valid,
    input  logic        adc_enable,
    input  logic [31:0] adc_data,
    input  logic        adc_or,
    input  logic        dma_ready,
    input  logic        ovf_clr,
    output logic        dma_valid,
    output logic [63:0] dma_data,
    output logic        dma_or,
    output logic        adc_ovf,
    output logic [15:0] ovf_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;

    logic          phase_q, phase_d;
    logic [31:0]   hold_q, hold_d;
    logic          hold_or_q, hold_or_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;

    logic [63:0]   mem_data_q [FIFO_DEPTH];
    logic          mem_or_q   [FIFO_DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic [63:0]   push_word;
    logic          push_or;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        accept    = adc_valid & adc_enable;
        push      = accept & phase_q;
        push_word = {adc_data, hold_q};
        push_or   = hold_or_q | adc_or;
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
        pop       = ~empty & dma_ready;
        push_ok   = push & (~full | pop);
        drop      = push & full & ~pop;
    end

    always_comb begin
        phase_d   = phase_q;
        hold_d    = hold_q;
        hold_or_d = hold_or_q;
        if (!adc_enable) begin
            phase_d = 1'b0;
        end else if (accept) begin
            if (!phase_q) begin
                phase_d   = 1'b1;
                hold_d    = adc_data;
                hold_or_d = adc_or;
            end else begin
                phase_d = 1'b0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        ovf_d    = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            phase_q   <= 1'b0;
            hold_q    <= 32'h0;
            hold_or_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            hold_or_q <= hold_or_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
        end
    end

    // When full with a pop pending, the write slot is the head being popped, so the overwrite is safe.
    always_ff @(posedge adc_clk) begin
        if (push_ok) begin
            mem_data_q[wr_ptr_q[AW-1:0]] <= push_word;
            mem_or_q[wr_ptr_q[AW-1:0]]   <= push_or;
        end
    end

    always_comb begin
        dma_valid = ~empty;
        dma_data  = mem_data_q[rd_ptr_q[AW-1:0]];
        dma_or    = mem_or_q[rd_ptr_q[AW-1:0]];
        adc_ovf   = ovf_q;
    end

`ifdef AXI_AD6676_CHAN_PACK_OVF_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // A drop in the same cycle as a clear restarts the count at one.
    always_comb begin
        cnt_d = cnt_q;
        if (drop) begin
            if (ovf_clr) begin
                cnt_d = 16'd1;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (ovf_clr) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovf_count = cnt_q;
`else
    assign ovf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_axi_ad6676_chan_pack.sv
// Self-checking bench for axi_ad6676_chan_pack: directed scenarios plus random traffic
// compared against a queue-based packing model.
module tb_axi_ad6676_chan_pack;

    localparam int DEPTH = 4;
`ifdef AXI_AD6676_CHAN_PACK_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        adc_clk;
    logic        adc_rst;
    logic        adc_valid;
    logic        adc_enable;
    logic [31:0] adc_data;
    logic        adc_or;
    logic        dma_ready;
    logic        ovf_clr;
    logic        dma_valid;
    logic [63:0] dma_data;
    logic        dma_or;
    logic        adc_ovf;
    logic [15:0] ovf_count;

    int checks = 0;
    int errors = 0;

    // Reference model: queued words, a pending half-word and the overflow state.
    logic [64:0] mQ[$];
    bit          mHalf = 1'b0;
    logic [31:0] mHoldData = 32'h0;
    bit          mHoldOr = 1'b0;
    bit          mOvf = 1'b0;
    int          mCnt = 0;

    axi_ad6676_chan_pack #(.FIFO_DEPTH(DEPTH)) dut (
        .adc_clk    (adc_clk),
        .adc_rst    (adc_rst),
        .adc_valid  (adc_valid),
        .adc_enable (adc_enable),
        .adc_data   (adc_data),
        .adc_or     (adc_or),
        .dma_ready  (dma_ready),
        .ovf_clr    (ovf_clr),
        .dma_valid  (dma_valid),
        .dma_data   (dma_data),
        .dma_or     (dma_or),
        .adc_ovf    (adc_ovf),
        .ovf_count  (ovf_count)
    );

    initial begin
        adc_clk = 1'b0;
        forever #5 adc_clk = ~adc_clk;
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, lets the clock edge pass, then advances the model.
    task automatic applyStimulus(input bit v, input bit e, input logic [31:0] d, input bit o,
                                 input bit r, input bit c);
        bit          popM;
        bit          pushM;
        bit          dropM;
        int          sizeBefore;
        logic [64:0] word;
        adc_valid  = v;
        adc_enable = e;
        adc_data   = d;
        adc_or     = o;
        dma_ready  = r;
        ovf_clr    = c;
        @(posedge adc_clk);
        popM  = (mQ.size() != 0) && r;
        pushM = 1'b0;
        dropM = 1'b0;
        word  = '0;
        if (!e) begin
            mHalf = 1'b0;
        end else if (v) begin
            if (!mHalf) begin
                mHoldData = d;
                mHoldOr   = o;
                mHalf     = 1'b1;
            end else begin
                word  = {o | mHoldOr, d, mHoldData};
                pushM = 1'b1;
                mHalf = 1'b0;
            end
        end
        sizeBefore = mQ.size();
        if (popM) void'(mQ.pop_front());
        if (pushM) begin
            if (sizeBefore < DEPTH || popM) mQ.push_back(word);
            else dropM = 1'b1;
        end
        if (dropM) begin
            mOvf = 1'b1;
            mCnt = c ? 1 : ((mCnt < 65535) ? mCnt + 1 : 65535);
        end else if (c) begin
            mOvf = 1'b0;
            mCnt = 0;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " dma_valid"}, 64'(dma_valid), 64'(mQ.size() != 0));
        if (mQ.size() != 0) begin
            checkVal({tag, " dma_data"}, dma_data, mQ[0][63:0]);
            checkVal({tag, " dma_or"}, 64'(dma_or), 64'(mQ[0][64]));
        end
        checkVal({tag, " adc_ovf"}, 64'(adc_ovf), 64'(mOvf));
        checkVal({tag, " ovf_count"}, 64'(ovf_count), CNT_EN ? 64'(mCnt) : 64'h0);
    endtask

    task automatic doReset();
        adc_valid  = 1'b0;
        adc_enable = 1'b0;
        adc_data   = 32'h0;
        adc_or     = 1'b0;
        dma_ready  = 1'b0;
        ovf_clr    = 1'b0;
        adc_rst    = 1'b1;
        #1;
        checkVal("reset dma_valid", 64'(dma_valid), 64'h0);
        checkVal("reset adc_ovf", 64'(adc_ovf), 64'h0);
        checkVal("reset ovf_count", 64'(ovf_count), 64'h0);
        mQ.delete();
        mHalf = 1'b0;
        mOvf  = 1'b0;
        mCnt  = 0;
        @(posedge adc_clk);
        #1;
        adc_rst = 1'b0;
    endtask

    task automatic drainFifo(input string tag, input int expected);
        int n = 0;
        for (int i = 0; i < 20 && dma_valid; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
            checkOutput(tag);
            n++;
        end
        checkVal({tag, " drained words"}, 64'(n), 64'(expected));
    endtask

    task automatic fillWords(input string tag, input int pairs);
        for (int i = 0; i < pairs; i++) begin
            applyStimulus(1'b1, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
            checkOutput(tag);
        end
    endtask

    initial begin
        logic [63:0] saved [4];
        logic [31:0] beatA;
        logic [31:0] beatB;
        adc_rst    = 1'b0;
        adc_valid  = 1'b0;
        adc_enable = 1'b0;
        adc_data   = 32'h0;
        adc_or     = 1'b0;
        dma_ready  = 1'b0;
        ovf_clr    = 1'b0;
        #2;
        doReset();

        // Basic packing and fall-through latency.
        applyStimulus(1'b1, 1'b1, 32'h00010000, 1'b0, 1'b1, 1'b0);
        checkOutput("s1 beat0");
        checkVal("s1 valid after first beat", 64'(dma_valid), 64'h0);
        applyStimulus(1'b1, 1'b1, 32'h00030002, 1'b0, 1'b1, 1'b0);
        checkOutput("s1 beat1");
        checkVal("s1 valid after second beat", 64'(dma_valid), 64'h1);
        checkVal("s1 word", dma_data, 64'h0003000200010000);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("s1 pop");
        checkVal("s1 empty after pop", 64'(dma_valid), 64'h0);

        // Overrange flag combines both beats of a word.
        applyStimulus(1'b1, 1'b1, 32'hAAAA5555, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
        checkOutput("s2 or word");
        checkVal("s2 dma_or set", 64'(dma_or), 64'h1);
        applyStimulus(1'b1, 1'b1, 32'h0BAD0BAD, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hC0FFEE00, 1'b0, 1'b1, 1'b0);
        checkOutput("s2 clean word");
        checkVal("s2 dma_or clear", 64'(dma_or), 64'h0);
        checkVal("s2 clean data", dma_data, 64'hC0FFEE000BAD0BAD);
        drainFifo("s2 drain", 1);

        // Dropping enable discards a pending half-word.
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000CCCC, 1'b0, 1'b0, 1'b0);
        checkOutput("s3 beat C");
        checkVal("s3 no word after C", 64'(dma_valid), 64'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000DDDD, 1'b0, 1'b0, 1'b0);
        checkOutput("s3 beat D");
        checkVal("s3 word DC", dma_data, 64'h0000DDDD0000CCCC);
        drainFifo("s3 drain", 1);

        // Push into a full FIFO while popping is not a drop.
        fillWords("s4 fill", 4);
        applyStimulus(1'b1, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, $urandom(), 1'b0, 1'b1, 1'b0);
        checkOutput("s4 push+pop");
        checkVal("s4 adc_ovf", 64'(adc_ovf), 64'h0);
        drainFifo("s4 drain", 4);

        // Ten pairs with no consumer: four stored, six dropped.
        for (int i = 0; i < 10; i++) begin
            beatA = $urandom();
            beatB = $urandom();
            if (i < 4) saved[i] = {beatB, beatA};
            applyStimulus(1'b1, 1'b1, beatA, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b1, beatB, 1'b0, 1'b0, 1'b0);
            checkOutput("s5 fill");
        end
        checkVal("s5 adc_ovf", 64'(adc_ovf), 64'h1);
        checkVal("s5 ovf_count", 64'(ovf_count), CNT_EN ? 64'd6 : 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkVal("s5 drain order", dma_data, saved[i]);
            applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
            checkOutput("s5 drain");
        end
        checkVal("s5 empty", 64'(dma_valid), 64'h0);

        // Clear coincident with a drop: set wins.
        fillWords("s6 fill", 4);
        applyStimulus(1'b1, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, $urandom(), 1'b0, 1'b0, 1'b1);
        checkOutput("s6 clr+drop");
        checkVal("s6 adc_ovf", 64'(adc_ovf), 64'h1);
        checkVal("s6 ovf_count", 64'(ovf_count), CNT_EN ? 64'd1 : 64'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("s6 clr");
        checkVal("s6 cleared", 64'(adc_ovf), 64'h0);

        // Reset mid-word empties the FIFO at once and restarts at phase 0.
        applyStimulus(1'b1, 1'b1, 32'h77777777, 1'b0, 1'b0, 1'b0);
        checkVal("s7 valid before reset", 64'(dma_valid), 64'h1);
        doReset();
        applyStimulus(1'b1, 1'b1, 32'h0000EEEE, 1'b0, 1'b0, 1'b0);
        checkOutput("s7 beat E");
        checkVal("s7 no word after E", 64'(dma_valid), 64'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
        checkOutput("s7 beat F");
        checkVal("s7 word FE", dma_data, 64'h0000FFFF0000EEEE);
        drainFifo("s7 drain", 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, $urandom(),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 19) == 0);
            checkOutput("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
